// File: rtl/ram_arbiter_pkg.sv
// Shared types for the two-port RAM arbiter: port identifiers, lock owner
// encoding and the one-cycle response tag.
package ram_arbiter_pkg;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_P0,
    OWN_P1
  } lock_owner_t;

  typedef struct packed {
    logic valid;
    logic port;
    logic err;
    logic was_read;
  } resp_tag_t;

  function automatic lock_owner_t owner_of(input logic port);
    return (port == PORT1) ? OWN_P1 : OWN_P0;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bus of the RAM arbiter: both ports' request fields plus
// grant/response flags and the shared read data.
interface ram_arbiter_if;

  logic        p0_req;
  logic        p0_lock;
  logic        p0_we;
  logic [15:0] p0_addr;
  logic [7:0]  p0_wdata;
  logic        p0_gnt;
  logic        p0_rvalid;
  logic        p0_err;

  logic        p1_req;
  logic        p1_lock;
  logic        p1_we;
  logic [15:0] p1_addr;
  logic [7:0]  p1_wdata;
  logic        p1_gnt;
  logic        p1_rvalid;
  logic        p1_err;

  logic [7:0]  rdata;

  modport slave (
    input  p0_req, p0_lock, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_lock, p1_we, p1_addr, p1_wdata,
    output p0_gnt, p0_rvalid, p0_err,
    output p1_gnt, p1_rvalid, p1_err,
    output rdata
  );

  modport master (
    output p0_req, p0_lock, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_lock, p1_we, p1_addr, p1_wdata,
    input  p0_gnt, p0_rvalid, p0_err,
    input  p1_gnt, p1_rvalid, p1_err,
    input  rdata
  );

endinterface

// File: rtl/ram_arbiter_rr.sv
// Two-way round-robin picker; a live lock (owner set, count below LOCK_MAX)
// overrides the rotation when both ports contend.
module ram_arbiter_rr
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned LOCK_MAX = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic [1:0]       req,
  input  logic             rr_last,
  input  lock_owner_t      lock_owner,
  input  logic [CNT_W-1:0] lock_cnt,
  output logic [1:0]       gnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

  logic lock_live;

  always_comb begin
    gnt       = '0;
    lock_live = (lock_owner != OWN_NONE) && (lock_cnt < CNT_MAX);
    unique case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        if (lock_live)
          gnt = (lock_owner == OWN_P1) ? 2'b10 : 2'b01;
        else
          gnt = (rr_last == PORT1) ? 2'b01 : 2'b10;
      end
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares a single-port byte RAM between instruction fetch (port 0) and the
// load/store unit (port 1); responses return one cycle after the grant.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LENGTH = 255,
  parameter int unsigned LOCK_MAX   = 4
) (
  input  logic        clk,
  input  logic        reset,
  ram_arbiter_if.slave bus,
  output logic [15:0] ram_address,
  output logic [7:0]  ram_data_in,
  output logic        ram_write_enable,
  output logic        ram_read_enable,
  input  logic [7:0]  ram_data_out
);

  localparam int unsigned      CNT_W    = $clog2(LOCK_MAX + 1);
  localparam logic [15:0]      ADDR_MAX = 16'(MEM_LENGTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LOCK_MAX);

  logic [1:0]       req;
  logic [1:0]       gnt;
  logic             granted;
  logic             sel;
  logic             sel_we;
  logic             sel_lock;
  logic             in_range;
  logic             rr_last;
  lock_owner_t      lock_owner;
  logic [CNT_W-1:0] lock_cnt;
  resp_tag_t        tag;

  assign req = {bus.p1_req, bus.p0_req} & {2{~reset}};

  ram_arbiter_rr #(
    .LOCK_MAX(LOCK_MAX),
    .CNT_W   (CNT_W)
  ) u_rr (
    .req       (req),
    .rr_last   (rr_last),
    .lock_owner(lock_owner),
    .lock_cnt  (lock_cnt),
    .gnt       (gnt)
  );

  // With no grant sel stays 0, so the RAM bus idles on port-0 values.
  always_comb begin
    granted          = |gnt;
    sel              = gnt[1];
    ram_address      = sel ? bus.p1_addr  : bus.p0_addr;
    ram_data_in      = sel ? bus.p1_wdata : bus.p0_wdata;
    sel_we           = sel ? bus.p1_we    : bus.p0_we;
    sel_lock         = sel ? bus.p1_lock  : bus.p0_lock;
    in_range         = (ram_address <= ADDR_MAX);
    ram_write_enable = granted &  sel_we & in_range;
    ram_read_enable  = granted & ~sel_we & in_range;
    bus.p0_gnt       = gnt[0];
    bus.p1_gnt       = gnt[1];
  end

  // A lock handed to a different port starts its own count instead of
  // inheriting the previous owner's saturated one.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last    <= PORT1;
      lock_owner <= OWN_NONE;
      lock_cnt   <= '0;
      tag        <= '0;
    end else begin
      tag <= '{valid: granted, port: sel, err: granted & ~in_range, was_read: ~sel_we};
      if (granted) begin
        rr_last <= sel;
        if (sel_lock) begin
          lock_owner <= owner_of(sel);
          if (lock_owner != owner_of(sel))
            lock_cnt <= CNT_W'(1);
          else if (lock_cnt != CNT_MAX)
            lock_cnt <= lock_cnt + CNT_W'(1);
        end else begin
          lock_owner <= OWN_NONE;
          lock_cnt   <= '0;
        end
      end else begin
        lock_owner <= OWN_NONE;
        lock_cnt   <= '0;
      end
    end
  end

  // Reset gates the response combinationally so a tag left from the cycle
  // before reset never surfaces.
  always_comb begin
    bus.p0_rvalid = tag.valid & (tag.port == PORT0) & ~reset;
    bus.p1_rvalid = tag.valid & (tag.port == PORT1) & ~reset;
    bus.p0_err    = bus.p0_rvalid & tag.err;
    bus.p1_err    = bus.p1_rvalid & tag.err;
    bus.rdata     = (tag.valid & tag.was_read & ~tag.err & ~reset) ? ram_data_out : '0;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed vector table, hand-written reset sequence,
// then random traffic against a transaction-level reference model.
module tb_ram_arbiter;

  localparam int MEM_LENGTH = 255;
  localparam int LOCK_MAX   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ram_address;
  logic [7:0]  ram_data_in;
  logic [7:0]  ram_data_out = 8'h00;
  logic        ram_write_enable;
  logic        ram_read_enable;
  logic [7:0]  ram [256] = '{default: 8'h00};

  always #5 clk = ~clk;

  ram_arbiter_if bus();

  ram_arbiter #(
    .MEM_LENGTH(MEM_LENGTH),
    .LOCK_MAX  (LOCK_MAX)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .ram_address     (ram_address),
    .ram_data_in     (ram_data_in),
    .ram_write_enable(ram_write_enable),
    .ram_read_enable (ram_read_enable),
    .ram_data_out    (ram_data_out)
  );

  always @(posedge clk) begin
    if (ram_write_enable) ram[ram_address[7:0]] <= ram_data_in;
    if (ram_read_enable)  ram_data_out <= ram[ram_address[7:0]];
  end

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  lock;
    logic [1:0]  we;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [7:0]  d0;
    logic [7:0]  d1;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic [1:0] g;
    logic [1:0] rv;
    logic [1:0] err;
    logic [7:0] rdata;
    logic       wen;
    logic       ren;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: who won last, current lock streak, pending response.
  int          m_last;
  int          m_owner;
  int          m_streak;
  int          m_win;
  bit          m_inr;
  logic [15:0] m_addr;
  bit          p_valid;
  int          p_port;
  bit          p_err;
  logic [7:0]  p_data;
  logic [7:0]  shadow [256] = '{default: 8'h00};

  logic [1:0]  e_g, e_rv, e_err;
  logic [7:0]  e_rdata;
  logic        e_wen, e_ren;

  function automatic stim_t mk(input logic rst, input logic [1:0] req, input logic [1:0] lock,
                               input logic [1:0] we, input logic [15:0] a0, input logic [15:0] a1,
                               input logic [7:0] d0, input logic [7:0] d1);
    stim_t s;
    s.rst = rst; s.req = req; s.lock = lock; s.we = we;
    s.a0 = a0; s.a1 = a1; s.d0 = d0; s.d1 = d1;
    return s;
  endfunction

  function automatic vec_t mkv(input stim_t s, input logic [1:0] g, input logic [1:0] rv,
                               input logic [1:0] err, input logic [7:0] rdata,
                               input logic wen, input logic ren);
    vec_t v;
    v.s = s; v.g = g; v.rv = rv; v.err = err; v.rdata = rdata; v.wen = wen; v.ren = ren;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input stim_t s);
    reset        = s.rst;
    bus.p0_req   = s.req[0];  bus.p1_req   = s.req[1];
    bus.p0_lock  = s.lock[0]; bus.p1_lock  = s.lock[1];
    bus.p0_we    = s.we[0];   bus.p1_we    = s.we[1];
    bus.p0_addr  = s.a0;      bus.p1_addr  = s.a1;
    bus.p0_wdata = s.d0;      bus.p1_wdata = s.d1;
  endtask

  task automatic model_predict(input stim_t s);
    e_rv = '0; e_err = '0; e_rdata = 8'h00;
    if (!s.rst && p_valid) begin
      e_rv[p_port]  = 1'b1;
      e_err[p_port] = p_err;
      e_rdata       = p_data;
    end
    m_win = -1;
    if (!s.rst) begin
      if (s.req == 2'b01) m_win = 0;
      else if (s.req == 2'b10) m_win = 1;
      else if (s.req == 2'b11)
        m_win = (m_owner >= 0 && m_streak < LOCK_MAX) ? m_owner : 1 - m_last;
    end
    e_g    = '0;
    m_addr = (m_win == 1) ? s.a1 : s.a0;
    m_inr  = int'(m_addr) <= MEM_LENGTH;
    e_wen  = 1'b0; e_ren = 1'b0;
    if (m_win >= 0) begin
      e_g[m_win] = 1'b1;
      e_wen = s.we[m_win] & m_inr;
      e_ren = ~s.we[m_win] & m_inr;
    end
  endtask

  task automatic model_commit(input stim_t s);
    if (s.rst) begin
      m_last = 1; m_owner = -1; m_streak = 0; p_valid = 0;
    end else begin
      p_valid = (m_win >= 0);
      if (m_win >= 0) begin
        p_port = m_win;
        p_err  = !m_inr;
        p_data = (!s.we[m_win] && m_inr) ? shadow[m_addr[7:0]] : 8'h00;
        if (s.we[m_win] && m_inr) shadow[m_addr[7:0]] = (m_win == 1) ? s.d1 : s.d0;
        m_last = m_win;
        if (s.lock[m_win]) begin
          m_streak = (m_owner == m_win) ? ((m_streak < LOCK_MAX) ? m_streak + 1 : LOCK_MAX) : 1;
          m_owner  = m_win;
        end else begin
          m_owner = -1; m_streak = 0;
        end
      end else begin
        m_owner = -1; m_streak = 0;
      end
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    apply(v.s);
    model_predict(v.s);
    #4;
    chk({tag, ".gnt"},   {30'd0, bus.p1_gnt, bus.p0_gnt},       {30'd0, v.g});
    chk({tag, ".rvalid"},{30'd0, bus.p1_rvalid, bus.p0_rvalid}, {30'd0, v.rv});
    chk({tag, ".err"},   {30'd0, bus.p1_err, bus.p0_err},       {30'd0, v.err});
    chk({tag, ".rdata"}, {24'd0, bus.rdata},                    {24'd0, v.rdata});
    chk({tag, ".ram_we"},{31'd0, ram_write_enable},             {31'd0, v.wen});
    chk({tag, ".ram_re"},{31'd0, ram_read_enable},              {31'd0, v.ren});
    model_commit(v.s);
    @(posedge clk); #1;
  endtask

  vec_t  tbl[$];
  stim_t idle, rst_s, cur;
  bit    held [2];

  initial begin
    idle  = mk(0, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 8'h0, 8'h0);
    rst_s = mk(1, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 8'h0, 8'h0);
    m_last = 1; m_owner = -1; m_streak = 0; p_valid = 0; p_port = 0; p_err = 0; p_data = 0;

    tbl.push_back(mkv(rst_s, 2'b00, 2'b00, 2'b00, 8'h00, 0, 0));
    tbl.push_back(mkv(rst_s, 2'b00, 2'b00, 2'b00, 8'h00, 0, 0));
    // p0 write then read back, then out-of-range read
    tbl.push_back(mkv(mk(0, 2'b01, 2'b00, 2'b01, 16'h0010, 16'h0, 8'hA5, 8'h0), 2'b01, 2'b00, 2'b00, 8'h00, 1, 0));
    tbl.push_back(mkv(mk(0, 2'b01, 2'b00, 2'b00, 16'h0010, 16'h0, 8'h00, 8'h0), 2'b01, 2'b01, 2'b00, 8'h00, 0, 1));
    tbl.push_back(mkv(idle, 2'b00, 2'b01, 2'b00, 8'hA5, 0, 0));
    tbl.push_back(mkv(mk(0, 2'b01, 2'b00, 2'b00, 16'h0100, 16'h0, 8'h00, 8'h0), 2'b01, 2'b00, 2'b00, 8'h00, 0, 0));
    tbl.push_back(mkv(idle, 2'b00, 2'b01, 2'b01, 8'h00, 0, 0));
    // set rr_last = 1, then six cycles of contention alternating p0/p1
    tbl.push_back(mkv(mk(0, 2'b10, 2'b00, 2'b00, 16'h0, 16'h0010, 8'h0, 8'h0), 2'b10, 2'b00, 2'b00, 8'h00, 0, 1));
    for (int unsigned i = 0; i < 6; i++)
      tbl.push_back(mkv(mk(0, 2'b11, 2'b00, 2'b00, 16'h0010, 16'h0011, 8'h0, 8'h0),
                        (i % 2 == 0) ? 2'b01 : 2'b10, (i % 2 == 0) ? 2'b10 : 2'b01, 2'b00,
                        (i == 0) ? 8'hA5 : ((i % 2 == 0) ? 8'h00 : 8'hA5), 0, 1));
    tbl.push_back(mkv(idle, 2'b00, 2'b10, 2'b00, 8'h00, 0, 0));
    // set rr_last = 0, then p1 holds lock against a waiting p0
    tbl.push_back(mkv(mk(0, 2'b01, 2'b00, 2'b00, 16'h0010, 16'h0, 8'h0, 8'h0), 2'b01, 2'b00, 2'b00, 8'h00, 0, 1));
    tbl.push_back(mkv(mk(0, 2'b11, 2'b10, 2'b00, 16'h0010, 16'h0011, 8'h0, 8'h0), 2'b10, 2'b01, 2'b00, 8'hA5, 0, 1));
    for (int unsigned i = 0; i < 3; i++)
      tbl.push_back(mkv(mk(0, 2'b11, 2'b10, 2'b00, 16'h0010, 16'h0011, 8'h0, 8'h0), 2'b10, 2'b10, 2'b00, 8'h00, 0, 1));
    tbl.push_back(mkv(mk(0, 2'b11, 2'b10, 2'b00, 16'h0010, 16'h0011, 8'h0, 8'h0), 2'b01, 2'b10, 2'b00, 8'h00, 0, 1));
    tbl.push_back(mkv(mk(0, 2'b11, 2'b10, 2'b00, 16'h0010, 16'h0011, 8'h0, 8'h0), 2'b10, 2'b01, 2'b00, 8'hA5, 0, 1));
    tbl.push_back(mkv(idle, 2'b00, 2'b10, 2'b00, 8'h00, 0, 0));
    // same-address write (p1) vs read (p0) with rr_last = 0
    tbl.push_back(mkv(mk(0, 2'b01, 2'b00, 2'b00, 16'h0010, 16'h0, 8'h0, 8'h0), 2'b01, 2'b00, 2'b00, 8'h00, 0, 1));
    tbl.push_back(mkv(mk(0, 2'b11, 2'b00, 2'b10, 16'h0020, 16'h0020, 8'h0, 8'h3C), 2'b10, 2'b01, 2'b00, 8'hA5, 1, 0));
    tbl.push_back(mkv(mk(0, 2'b01, 2'b00, 2'b00, 16'h0020, 16'h0, 8'h0, 8'h0), 2'b01, 2'b10, 2'b00, 8'h00, 0, 1));
    tbl.push_back(mkv(idle, 2'b00, 2'b01, 2'b00, 8'h3C, 0, 0));

    for (int unsigned i = 0; i < tbl.size(); i++)
      run_vec($sformatf("vec%0d", i), tbl[i]);

    // Reset lands in the cycle a p1 read response is due: it must be squashed.
    run_vec("rst_sq0", mkv(mk(0, 2'b10, 2'b00, 2'b00, 16'h0, 16'h0020, 8'h0, 8'h0), 2'b10, 2'b00, 2'b00, 8'h00, 0, 1));
    run_vec("rst_sq1", mkv(mk(1, 2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 8'h0, 8'h0), 2'b00, 2'b00, 2'b00, 8'h00, 0, 0));
    run_vec("rst_sq2", mkv(mk(0, 2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 8'h0, 8'h0), 2'b01, 2'b00, 2'b00, 8'h00, 0, 1));
    run_vec("rst_sq3", mkv(idle, 2'b00, 2'b01, 2'b00, 8'hA5, 0, 0));

    // Random traffic; requesters hold their fields until granted.
    cur = idle;
    held[0] = 0; held[1] = 0;
    for (int unsigned cyc = 0; cyc < 800; cyc++) begin
      cur.rst = ($urandom_range(0, 99) == 0);
      for (int p = 0; p < 2; p++) begin
        if (!held[p] && $urandom_range(0, 3) != 0) begin
          logic [15:0] a;
          a = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(250, 300)) : 16'($urandom_range(0, 31));
          held[p]    = 1;
          cur.we[p]  = ($urandom_range(0, 2) == 0);
          if (p == 0) begin cur.a0 = a; cur.d0 = 8'($urandom); end
          else        begin cur.a1 = a; cur.d1 = 8'($urandom); end
        end
        cur.req[p]  = held[p];
        cur.lock[p] = ($urandom_range(0, 2) != 0);
      end
      apply(cur);
      model_predict(cur);
      #4;
      chk("rnd.gnt",    {30'd0, bus.p1_gnt, bus.p0_gnt},       {30'd0, e_g});
      chk("rnd.rvalid", {30'd0, bus.p1_rvalid, bus.p0_rvalid}, {30'd0, e_rv});
      chk("rnd.err",    {30'd0, bus.p1_err, bus.p0_err},       {30'd0, e_err});
      chk("rnd.rdata",  {24'd0, bus.rdata},                    {24'd0, e_rdata});
      chk("rnd.ram_we", {31'd0, ram_write_enable},             {31'd0, e_wen});
      chk("rnd.ram_re", {31'd0, ram_read_enable},              {31'd0, e_ren});
      if (m_win >= 0) chk("rnd.ram_addr", {16'd0, ram_address}, {16'd0, m_addr});
      for (int p = 0; p < 2; p++)
        if (e_g[p]) held[p] = 0;
      model_commit(cur);
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
